// File: rtl/mem_stage_ctl.sv
// mem_stage_ctl: memory stage between the EX/MEM and MEM/WB pipeline registers.
//
// Drives a variable-latency data-memory port. The handshake works like this:
// dmem_req is a registered level. It rises on the edge that accepts an aligned
// memory op. It stays high, with dmem_we/addr/be/wdata stable, until the edge
// on which dmem_ack is sampled high; dmem_rdata is valid in that same cycle.
// dmem_ack is ignored while no request is outstanding.
//
// Ports:
//   clk, reset (async, active-low)
//   valid_in + EX/MEM fields (*_in)      instruction arriving from EX/MEM
//   dmem_req/we/addr/be/wdata, dmem_ack/rdata   data-memory port
//   stall                                 hold EX/MEM while an access is outstanding
//   valid_out, misalign_out + *_out       registered MEM/WB fields
//   state_dbg                             current FSM state (0 idle, 1 waiting)
// Vectors are [0:N-1] with bit 0 the MSB. Byte lane 0 is bits [0:7] (big-endian).
module mem_stage_ctl #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int FP_W   = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valid_in,
    input  logic [0:DATA_W-1]   nextPC_in,
    input  logic [0:DATA_W-1]   aluResult_in,
    input  logic [0:DATA_W-1]   opB_in,
    input  logic [0:REG_W-1]    destReg_in,
    input  logic [0:REG_W-1]    fDestReg_in,
    input  logic [0:FP_W-1]     fbusW_in,
    input  logic                PCtoReg_in,
    input  logic                RegWrite_in,
    input  logic                MemToReg_in,
    input  logic                MemWrite_in,
    input  logic                loadSign_in,
    input  logic                FPRegWrite_in,
    input  logic                mul_in,
    input  logic [0:1]          DSize_in,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [0:DATA_W-1]   dmem_addr,
    output logic [0:DATA_W/8-1] dmem_be,
    output logic [0:DATA_W-1]   dmem_wdata,
    input  logic                dmem_ack,
    input  logic [0:DATA_W-1]   dmem_rdata,
    output logic                stall,
    output logic                valid_out,
    output logic                misalign_out,
    output logic [0:DATA_W-1]   nextPC_out,
    output logic [0:DATA_W-1]   aluResult_out,
    output logic [0:DATA_W-1]   dataOut_out,
    output logic [0:REG_W-1]    destReg_out,
    output logic [0:REG_W-1]    fDestReg_out,
    output logic [0:FP_W-1]     fbusW_out,
    output logic [0:1]          DSize_out,
    output logic                PCtoReg_out,
    output logic                RegWrite_out,
    output logic                MemToReg_out,
    output logic                loadSign_out,
    output logic                FPRegWrite_out,
    output logic                mul_out,
    output logic [0:0]          state_dbg
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0] state;

    // Fields latched while a memory access is outstanding.
    logic [0:DATA_W-1] npc_q, alu_q;
    logic [0:REG_W-1]  dest_q, fdest_q;
    logic [0:FP_W-1]   fbus_q;
    logic [0:1]        dsize_q;
    logic              pctoreg_q, regwrite_q, memtoreg_q, loadsign_q, fpregwrite_q, mul_q;

    // Request-side decode of the incoming instruction.
    logic [OFF_W-1:0]  off_in;
    int                lane_in;
    logic              is_mem_in, misalign_in;
    logic [0:NB-1]     be_in;
    logic [0:DATA_W-1] wdata_in, addr_in;

    assign off_in    = aluResult_in[DATA_W-OFF_W +: OFF_W];
    assign lane_in   = int'(off_in);
    assign is_mem_in = MemToReg_in | MemWrite_in;
    assign addr_in   = {aluResult_in[0:DATA_W-OFF_W-1], {OFF_W{1'b0}}};

    always_comb begin
        be_in       = '1;
        wdata_in    = opB_in;
        misalign_in = 1'b0;
        case (DSize_in)
            2'b00: begin
                for (int i = 0; i < NB; i++) be_in[i] = (i == lane_in);
                wdata_in = {NB{opB_in[DATA_W-8 +: 8]}};
            end
            2'b01: begin
                for (int i = 0; i < NB; i++) be_in[i] = (i == lane_in) || (i == lane_in + 1);
                wdata_in    = {(NB/2){opB_in[DATA_W-16 +: 16]}};
                misalign_in = off_in[0];
            end
            default: begin
                // 11 is reserved and behaves exactly like a word access.
                misalign_in = (off_in != '0);
            end
        endcase
    end

    // Load extraction from the word returned by memory, using the latched offset.
    int                lane_q;
    logic [7:0]        ld_b;
    logic [15:0]       ld_h;
    logic [0:DATA_W-1] load_data;

    assign lane_q = int'(alu_q[DATA_W-OFF_W +: OFF_W]);

    always_comb begin
        ld_b = dmem_rdata[lane_q*8 +: 8];
        // Aligned halves start on an even lane; clearing bit 0 keeps the select in range.
        ld_h = dmem_rdata[(lane_q & ~1)*8 +: 16];
        case (dsize_q)
            2'b00:   load_data = {{(DATA_W-8){loadsign_q & ld_b[7]}}, ld_b};
            2'b01:   load_data = {{(DATA_W-16){loadsign_q & ld_h[15]}}, ld_h};
            default: load_data = dmem_rdata;
        endcase
    end

    assign stall     = (state == S_WAIT);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= S_IDLE;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_be        <= '0;
            dmem_wdata     <= '0;
            valid_out      <= 1'b0;
            misalign_out   <= 1'b0;
            nextPC_out     <= '0;
            aluResult_out  <= '0;
            dataOut_out    <= '0;
            destReg_out    <= '0;
            fDestReg_out   <= '0;
            fbusW_out      <= '0;
            DSize_out      <= '0;
            PCtoReg_out    <= 1'b0;
            RegWrite_out   <= 1'b0;
            MemToReg_out   <= 1'b0;
            loadSign_out   <= 1'b0;
            FPRegWrite_out <= 1'b0;
            mul_out        <= 1'b0;
            npc_q          <= '0;
            alu_q          <= '0;
            dest_q         <= '0;
            fdest_q        <= '0;
            fbus_q         <= '0;
            dsize_q        <= '0;
            pctoreg_q      <= 1'b0;
            regwrite_q     <= 1'b0;
            memtoreg_q     <= 1'b0;
            loadsign_q     <= 1'b0;
            fpregwrite_q   <= 1'b0;
            mul_q          <= 1'b0;
        end else begin
            // Default: no result this cycle. Payload holds; write enables drop.
            valid_out      <= 1'b0;
            PCtoReg_out    <= 1'b0;
            RegWrite_out   <= 1'b0;
            MemToReg_out   <= 1'b0;
            FPRegWrite_out <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (valid_in) begin
                        if (is_mem_in && !misalign_in) begin
                            npc_q        <= nextPC_in;
                            alu_q        <= aluResult_in;
                            dest_q       <= destReg_in;
                            fdest_q      <= fDestReg_in;
                            fbus_q       <= fbusW_in;
                            dsize_q      <= DSize_in;
                            pctoreg_q    <= PCtoReg_in;
                            regwrite_q   <= RegWrite_in;
                            memtoreg_q   <= MemToReg_in;
                            loadsign_q   <= loadSign_in;
                            fpregwrite_q <= FPRegWrite_in;
                            mul_q        <= mul_in;
                            dmem_req     <= 1'b1;
                            dmem_we      <= MemWrite_in;
                            dmem_addr    <= addr_in;
                            dmem_be      <= be_in;
                            dmem_wdata   <= wdata_in;
                            state        <= S_WAIT;
                        end else begin
                            // Non-memory op, or a misaligned access that never reaches memory.
                            valid_out      <= 1'b1;
                            misalign_out   <= is_mem_in;
                            nextPC_out     <= nextPC_in;
                            aluResult_out  <= aluResult_in;
                            dataOut_out    <= '0;
                            destReg_out    <= destReg_in;
                            fDestReg_out   <= fDestReg_in;
                            fbusW_out      <= fbusW_in;
                            DSize_out      <= DSize_in;
                            PCtoReg_out    <= PCtoReg_in;
                            RegWrite_out   <= RegWrite_in & ~is_mem_in;
                            MemToReg_out   <= 1'b0;
                            loadSign_out   <= loadSign_in;
                            FPRegWrite_out <= FPRegWrite_in & ~is_mem_in;
                            mul_out        <= mul_in;
                        end
                    end
                end
                default: begin
                    if (dmem_ack) begin
                        dmem_req       <= 1'b0;
                        dmem_we        <= 1'b0;
                        valid_out      <= 1'b1;
                        misalign_out   <= 1'b0;
                        nextPC_out     <= npc_q;
                        aluResult_out  <= alu_q;
                        dataOut_out    <= dmem_we ? '0 : load_data;
                        destReg_out    <= dest_q;
                        fDestReg_out   <= fdest_q;
                        fbusW_out      <= fbus_q;
                        DSize_out      <= dsize_q;
                        PCtoReg_out    <= pctoreg_q;
                        RegWrite_out   <= regwrite_q;
                        MemToReg_out   <= memtoreg_q;
                        loadSign_out   <= loadsign_q;
                        FPRegWrite_out <= fpregwrite_q;
                        mul_out        <= mul_q;
                        state          <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctl.sv
// tb_mem_stage_ctl: directed and randomized checks of mem_stage_ctl against a
// transaction-level reference model (byte lanes computed by shifting numeric words).
module tb_mem_stage_ctl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] nextPC_in = '0, aluResult_in = '0, opB_in = '0;
    logic [4:0]  destReg_in = '0, fDestReg_in = '0;
    logic [63:0] fbusW_in = '0;
    logic        PCtoReg_in = 0, RegWrite_in = 0, MemToReg_in = 0, MemWrite_in = 0;
    logic        loadSign_in = 0, FPRegWrite_in = 0, mul_in = 0;
    logic [1:0]  DSize_in = '0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        stall, valid_out, misalign_out;
    logic [31:0] nextPC_out, aluResult_out, dataOut_out;
    logic [4:0]  destReg_out, fDestReg_out;
    logic [63:0] fbusW_out;
    logic [1:0]  DSize_out;
    logic        PCtoReg_out, RegWrite_out, MemToReg_out, loadSign_out, FPRegWrite_out, mul_out;
    logic [0:0]  state_dbg;

    int checks = 0;
    int failures = 0;

    mem_stage_ctl dut (
        .clk(clk), .reset(reset), .valid_in(valid_in),
        .nextPC_in(nextPC_in), .aluResult_in(aluResult_in), .opB_in(opB_in),
        .destReg_in(destReg_in), .fDestReg_in(fDestReg_in), .fbusW_in(fbusW_in),
        .PCtoReg_in(PCtoReg_in), .RegWrite_in(RegWrite_in), .MemToReg_in(MemToReg_in),
        .MemWrite_in(MemWrite_in), .loadSign_in(loadSign_in), .FPRegWrite_in(FPRegWrite_in),
        .mul_in(mul_in), .DSize_in(DSize_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall(stall), .valid_out(valid_out), .misalign_out(misalign_out),
        .nextPC_out(nextPC_out), .aluResult_out(aluResult_out), .dataOut_out(dataOut_out),
        .destReg_out(destReg_out), .fDestReg_out(fDestReg_out), .fbusW_out(fbusW_out),
        .DSize_out(DSize_out), .PCtoReg_out(PCtoReg_out), .RegWrite_out(RegWrite_out),
        .MemToReg_out(MemToReg_out), .loadSign_out(loadSign_out),
        .FPRegWrite_out(FPRegWrite_out), .mul_out(mul_out), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---- reference model ----
    function automatic bit model_aligned(input logic [1:0] size, input int off);
        if (size == 2'b00) return 1'b1;
        if (size == 2'b01) return (off % 2) == 0;
        return off == 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] size, input int off);
        if (size == 2'b00) return 4'b1000 >> off;
        if (size == 2'b01) return 4'b1100 >> off;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] opb);
        if (size == 2'b00) return (opb & 32'hFF) * 32'h0101_0101;
        if (size == 2'b01) return (opb & 32'hFFFF) * 32'h0001_0001;
        return opb;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input int off,
                                               input bit sgn, input logic [31:0] rd);
        logic [31:0] v;
        if (size == 2'b00) begin
            v = (rd >> (8 * (3 - off))) & 32'hFF;
            if (sgn && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2'b01) begin
            v = (rd >> (8 * (2 - off))) & 32'hFFFF;
            if (sgn && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // One instruction end to end, followed by one idle cycle.
    task automatic run_op(input bit rd, input bit wr, input logic [31:0] addr,
                          input logic [31:0] opb, input logic [1:0] size, input bit sgn,
                          input bit rw, input int lat, input logic [31:0] rdata);
        logic [31:0] npc;
        logic [4:0]  dst, fdst;
        logic [63:0] fbus;
        bit          p2r, fpw, mv, is_mem, ok;
        int          off;
        npc  = $urandom;
        dst  = 5'($urandom_range(0, 31));
        fdst = 5'($urandom_range(0, 31));
        fbus = {$urandom, $urandom};
        p2r  = 1'($urandom_range(0, 1));
        fpw  = 1'($urandom_range(0, 1));
        mv   = 1'($urandom_range(0, 1));
        off  = int'(addr % 4);
        is_mem = rd | wr;
        ok     = model_aligned(size, off);

        valid_in = 1; nextPC_in = npc; aluResult_in = addr; opB_in = opb;
        destReg_in = dst; fDestReg_in = fdst; fbusW_in = fbus; PCtoReg_in = p2r;
        RegWrite_in = rw; MemToReg_in = rd; MemWrite_in = wr; loadSign_in = sgn;
        FPRegWrite_in = fpw; mul_in = mv; DSize_in = size;
        step();
        // Scramble inputs: only latched values may reach the outputs.
        valid_in = 0; aluResult_in = $urandom; opB_in = $urandom; nextPC_in = $urandom;
        RegWrite_in = 1'($urandom_range(0, 1)); DSize_in = 2'($urandom_range(0, 3));
        MemToReg_in = 1'($urandom_range(0, 1)); MemWrite_in = 1'($urandom_range(0, 1));

        if (is_mem && ok) begin
            chk("req_up", dmem_req, 1);
            chk("we", dmem_we, wr);
            chk("addr", dmem_addr, addr & 32'hFFFF_FFFC);
            chk("be", dmem_be, model_be(size, off));
            if (wr) chk("wdata", dmem_wdata, model_wdata(size, opb));
            chk("valid_during_wait", valid_out, 0);
            for (int i = 1; i <= lat; i++) begin
                if (i == lat) begin dmem_ack = 1; dmem_rdata = rdata; end
                else dmem_rdata = $urandom;
                chk("stall_wait", stall, 1);
                chk("port_stable", {dmem_req, dmem_we, dmem_addr, dmem_be},
                    {1'b1, wr, addr & 32'hFFFF_FFFC, model_be(size, off)});
                step();
            end
            dmem_ack = 0;
            chk("req_drop", dmem_req, 0);
            chk("data_out", dataOut_out, wr ? 32'h0 : model_load(size, off, sgn, rdata));
            chk("memtoreg_out", MemToReg_out, rd);
            chk("regwrite_out", RegWrite_out, rw);
            chk("fpregwrite_out", FPRegWrite_out, fpw);
            chk("misalign_clear", misalign_out, 0);
        end else begin
            chk("no_req", dmem_req, 0);
            chk("misalign", misalign_out, is_mem);
            chk("regwrite_out", RegWrite_out, is_mem ? 1'b0 : rw);
            chk("memtoreg_out", MemToReg_out, 0);
            chk("fpregwrite_out", FPRegWrite_out, is_mem ? 1'b0 : fpw);
            if (!is_mem) chk("data_out_alu", dataOut_out, 0);
        end
        chk("valid_out", valid_out, 1);
        chk("stall_after", stall, 0);
        chk("alu_out", aluResult_out, addr);
        chk("npc_out", nextPC_out, npc);
        chk("regs_out", {destReg_out, fDestReg_out, DSize_out, loadSign_out, mul_out, PCtoReg_out},
            {dst, fdst, size, sgn, mv, p2r});
        chk("fbus_out", fbusW_out, fbus);

        // Idle cycle; a stray ack here must be ignored.
        dmem_ack = 1'($urandom_range(0, 1));
        step();
        dmem_ack = 0;
        chk("idle_valid", valid_out, 0);
        chk("idle_we_off", {RegWrite_out, PCtoReg_out, MemToReg_out, FPRegWrite_out}, 4'b0);
        chk("idle_hold", aluResult_out, addr);
        chk("idle_no_req", {dmem_req, stall}, 2'b00);
    endtask

    initial begin
        // Reset held low with toggling inputs: everything stays at zero.
        reset = 0;
        for (int i = 0; i < 4; i++) begin
            valid_in = 1; aluResult_in = $urandom; MemToReg_in = 1'($urandom_range(0, 1));
            MemWrite_in = 1'($urandom_range(0, 1)); RegWrite_in = 1; dmem_ack = 1'($urandom_range(0, 1));
            step();
            chk("reset_outputs", |{dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, valid_out,
                misalign_out, nextPC_out, aluResult_out, dataOut_out, destReg_out, fDestReg_out,
                fbusW_out, DSize_out, PCtoReg_out, RegWrite_out, MemToReg_out, loadSign_out,
                FPRegWrite_out, mul_out}, 0);
            chk("reset_stall", stall, 0);
        end
        valid_in = 0; MemToReg_in = 0; MemWrite_in = 0; RegWrite_in = 0; dmem_ack = 0;
        reset = 1;
        step();
        chk("post_reset_valid", valid_out, 0);
        step();
        chk("post_reset_valid2", valid_out, 0);

        // ALU pass-through.
        run_op(0, 0, 32'h1234_5678, 32'h0, 2'b10, 0, 1, 0, 32'h0);
        chk("alu_const", aluResult_out, 32'h1234_5678);

        // Store byte at lane 2, ack on the third wait cycle.
        run_op(0, 1, 32'h0000_0102, 32'h0000_00AB, 2'b00, 0, 0, 3, 32'h0);
        chk("sb_wdata_const", dmem_wdata, 32'hABAB_ABAB);
        chk("sb_be_const", dmem_be, 4'b0010);

        // Load half, signed then unsigned.
        run_op(1, 0, 32'h0000_0202, 32'h0, 2'b01, 1, 1, 1, 32'h1234_F00D);
        chk("lh_signed_const", dataOut_out, 32'hFFFF_F00D);
        run_op(1, 0, 32'h0000_0202, 32'h0, 2'b01, 0, 1, 1, 32'h1234_F00D);
        chk("lh_unsigned_const", dataOut_out, 32'h0000_F00D);

        // Misaligned word, and reserved size treated as word.
        run_op(1, 0, 32'h0000_0301, 32'h0, 2'b10, 0, 1, 1, 32'h0);
        run_op(1, 0, 32'h0000_0402, 32'h0, 2'b11, 0, 1, 1, 32'h0);
        run_op(0, 1, 32'h0000_0503, 32'h55, 2'b01, 0, 1, 1, 32'h0);

        // Reset in the middle of an outstanding load; a late ack is ignored.
        valid_in = 1; MemToReg_in = 1; MemWrite_in = 0; aluResult_in = 32'h0000_0600;
        DSize_in = 2'b10; RegWrite_in = 1;
        step();
        valid_in = 0; MemToReg_in = 0;
        chk("rst_wait_req", dmem_req, 1);
        step();
        reset = 0;
        #1;
        chk("rst_wait_cleared", {dmem_req, stall, valid_out}, 3'b000);
        reset = 1;
        step();
        dmem_ack = 1; dmem_rdata = 32'hDEAD_BEEF;
        step();
        dmem_ack = 0;
        chk("late_ack_valid", valid_out, 0);
        chk("late_ack_idle", {stall, dmem_req}, 2'b00);
        run_op(0, 0, 32'hCAFE_0001, 32'h0, 2'b00, 0, 1, 0, 32'h0);

        // Randomized instruction mix.
        for (int n = 0; n < 60; n++) begin
            int kind;
            kind = $urandom_range(0, 2);
            run_op(kind == 1, kind == 2, $urandom, $urandom, 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(1, 4), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
